vdp1_cmd_fetch: RTL and testbench

- Command-list reader for VDP1. On a plot start it walks the command tables in VRAM from address 0 and fetches each 32-byte table in CMDTBL_t layout.
- It resolves END, skip and jump modes (next/assign/call/return) and hands each drawable or clip/coordinate command to the draw engine over a valid/ready handshake.
- It also maintains COPR, LOPR and the EDSR CEF/BEF flags for the register block.

---
 rtl/vdp1_cmd_fetch_if.sv | 23 ++
 rtl/vdp1_cmd_fetch.sv | 109 ++++++++++
 tb/tb_vdp1_cmd_fetch.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp1_cmd_fetch_if.sv
// vdp1_cmd_fetch_if: VRAM read port, draw-engine command handoff and list status
interface vdp1_cmd_fetch_if;
  logic [17:0] vram_a;
  logic vram_rd;
  logic [15:0] vram_d;
  logic vram_rdy;
  logic [255:0] cmd_tbl;
  logic cmd_valid;
  logic cmd_ready;
  logic [15:0] copr;
  logic [15:0] lopr;
  logic cef;
  logic bef;
  logic busy;
  modport master (
    output vram_a, vram_rd, cmd_tbl, cmd_valid, copr, lopr, cef, bef, busy,
    input vram_d, vram_rdy, cmd_ready
  );
  modport slave (
    input vram_a, vram_rd, cmd_tbl, cmd_valid, copr, lopr, cef, bef, busy,
    output vram_d, vram_rdy, cmd_ready
  );
endinterface

// File: rtl/vdp1_cmd_fetch.sv
// vdp1_cmd_fetch: walks VDP1 command tables in VRAM and hands drawable commands to the draw engine
module vdp1_cmd_fetch #(
  parameter int RET_DEPTH = 1
) (
  input logic clk,
  input logic rst,
  input logic ce,
  input logic start,
  vdp1_cmd_fetch_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_CTRL, RD_LINK, RD_BODY, ISSUE, NEXT} state_t;
  state_t state;
  logic [3:0] widx;
  logic [15:0] ret;
  logic [RET_DEPTH-1:0] ret_v;
  logic [2:0] jp;
  logic [15:0] link;
  logic [15:0] copr_inc;
  logic [15:0] copr_nxt;
  // CMDCTRL and masked CMDLINK live in table words 0 and 1, so they double as the jump decode source
  assign jp = bus.cmd_tbl[14:12];
  assign link = bus.cmd_tbl[31:16];
  assign copr_inc = bus.copr + 16'd4;
  assign copr_nxt = jp[1:0] == 2'd0 ? copr_inc :
                    !jp[1] ? link :
                    !jp[0] ? link :
                    |ret_v ? ret : copr_inc;
  assign bus.vram_a = {bus.copr, 2'b00} + {14'd0, widx};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      widx <= '0;
      ret <= '0;
      ret_v <= '0;
      bus.vram_rd <= 1'b0;
      bus.cmd_tbl <= '0;
      bus.cmd_valid <= 1'b0;
      bus.copr <= '0;
      bus.lopr <= '0;
      bus.cef <= 1'b0;
      bus.bef <= 1'b0;
      bus.busy <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: if (start) begin
          bus.bef <= bus.cef;
          bus.cef <= 1'b0;
          bus.copr <= '0;
          ret_v <= '0;
          bus.busy <= 1'b1;
          widx <= '0;
          bus.vram_rd <= 1'b1;
          state <= RD_CTRL;
        end
        RD_CTRL: if (bus.vram_rdy) begin
          bus.cmd_tbl[15:0] <= bus.vram_d;
          if (bus.vram_d[15]) begin
            bus.cef <= 1'b1;
            bus.busy <= 1'b0;
            bus.vram_rd <= 1'b0;
            state <= IDLE;
          end else begin
            widx <= 4'd1;
            state <= RD_LINK;
          end
        end
        RD_LINK: if (bus.vram_rdy) begin
          bus.cmd_tbl[31:16] <= {bus.vram_d[15:2], 2'b00};
          if (jp[2]) begin
            bus.lopr <= bus.copr;
            bus.vram_rd <= 1'b0;
            state <= NEXT;
          end else begin
            widx <= 4'd2;
            state <= RD_BODY;
          end
        end
        RD_BODY: if (bus.vram_rdy) begin
          bus.cmd_tbl[{widx, 4'd0} +: 16] <= bus.vram_d;
          if (widx == 4'd14) begin
            bus.vram_rd <= 1'b0;
            bus.cmd_valid <= 1'b1;
            state <= ISSUE;
          end else begin
            widx <= widx + 4'd1;
          end
        end
        ISSUE: if (bus.cmd_ready) begin
          bus.cmd_valid <= 1'b0;
          bus.lopr <= bus.copr;
          state <= NEXT;
        end
        NEXT: begin
          bus.copr <= copr_nxt;
          // a call only saves the return point when the single-level slot is free
          if (jp[1:0] == 2'd2 && !(|ret_v)) begin
            ret <= copr_inc;
            ret_v <= '1;
          end
          if (jp[1:0] == 2'd3) ret_v <= '0;
          widx <= '0;
          bus.vram_rd <= 1'b1;
          state <= RD_CTRL;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vdp1_cmd_fetch.sv
// tb_vdp1_cmd_fetch: randomized VRAM/draw-engine environment with a list-walk reference model and scoreboards
module tb_vdp1_cmd_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic start = 1'b0;
  vdp1_cmd_fetch_if bus();
  vdp1_cmd_fetch dut (.clk(clk), .rst(rst), .ce(ce), .start(start), .bus(bus.master));
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] copr;
    logic [255:0] tbl;
  } cmd_t;
  cmd_t exp_cmd[$];
  logic [17:0] exp_addr[$];
  logic [15:0] mem [int];
  int n_cmp = 0;
  int n_err = 0;
  bit ce_rand = 0;
  bit hold_low = 0;
  int lat = 0;
  logic [15:0] m_lopr = 0;
  logic [15:0] m_copr = 0;
  bit m_cef = 0;
  bit stab_v = 0;
  logic [255:0] stab_tbl = '0;

  function automatic logic [15:0] rdm(input int a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr_tbl(input logic [15:0] c, input logic [15:0] ctrl, input logic [15:0] lnk);
    int b;
    b = {c, 2'b00};
    mem[b] = ctrl;
    mem[b + 1] = lnk;
    for (int w = 2; w < 15; w++) mem[b + w] = 16'($urandom);
  endtask

  task automatic wr_rand(input logic [15:0] c);
    logic [15:0] ctrl;
    logic [15:0] lnk;
    ctrl = $urandom_range(0, 5) == 0 ? (16'h8000 | 16'($urandom)) : {1'b0, 3'($urandom), 12'($urandom)};
    lnk = {8'h00, 6'($urandom), 2'($urandom)};
    wr_tbl(c, ctrl, lnk);
  endtask

  // Reference walk: follows the list table by table; returns 0 if no END within 16 tables
  function automatic bit model(input bit doit);
    logic [15:0] c = 0;
    logic [15:0] rt = 0;
    logic [15:0] lo = m_lopr;
    logic [15:0] ln;
    logic [15:0] ct;
    logic [255:0] t;
    bit rv = 0;
    int base;
    for (int s = 0; s < 16; s++) begin
      base = {c, 2'b00};
      ct = rdm(base);
      if (doit) exp_addr.push_back(18'(base));
      if (ct[15]) begin
        if (doit) begin
          m_lopr = lo;
          m_copr = c;
        end
        return 1;
      end
      if (doit) exp_addr.push_back(18'(base + 1));
      ln = rdm(base + 1) & 16'hFFFC;
      if (!ct[14]) begin
        t = '0;
        t[15:0] = ct;
        t[31:16] = ln;
        for (int w = 2; w < 15; w++) begin
          t[w*16 +: 16] = rdm(base + w);
          if (doit) exp_addr.push_back(18'(base + w));
        end
        if (doit) exp_cmd.push_back('{c, t});
      end
      lo = c;
      case (ct[13:12])
        2'd0: c = c + 16'd4;
        2'd1: c = ln;
        2'd2: begin
          if (!rv) begin
            rt = c + 16'd4;
            rv = 1;
          end
          c = ln;
        end
        default: if (rv) begin
          c = rt;
          rv = 0;
        end else c = c + 16'd4;
      endcase
    end
    return 0;
  endfunction

  // VRAM responder and draw-engine ready generator
  initial begin
    bus.vram_rdy = 1'b0;
    bus.vram_d = '0;
    bus.cmd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) bus.vram_rdy = 1'b0;
      else if (bus.vram_rdy && ce) begin
        bus.vram_rdy = 1'b0;
        lat = $urandom_range(0, 7);
      end
      ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.cmd_ready = !hold_low && ($urandom_range(0, 2) != 0);
      if (!rst && bus.vram_rd && !bus.vram_rdy) begin
        if (lat == 0) begin
          bus.vram_rdy = 1'b1;
          bus.vram_d = rdm(int'(bus.vram_a));
        end else lat--;
      end
    end
  end

  // Monitor: checks every VRAM read and command handoff the next edge will accept
  initial forever begin
    cmd_t e;
    @(negedge clk);
    #1;
    if (rst) stab_v = 0;
    else begin
      if (ce && bus.vram_rd && bus.vram_rdy) begin
        if (exp_addr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL vram_a: unexpected read at %h, none expected", bus.vram_a);
        end else chk("vram_a", bus.vram_a, exp_addr.pop_front());
      end
      if (stab_v && bus.cmd_valid) chk("cmd_tbl_stable", bus.cmd_tbl, stab_tbl);
      if (ce && bus.cmd_valid && bus.cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL cmd: unexpected handoff at copr %h, none expected", bus.copr);
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd_copr", bus.copr, e.copr);
          chk("cmd_tbl", bus.cmd_tbl, e.tbl);
        end
      end
      stab_v = bus.cmd_valid && !(ce && bus.cmd_ready);
      stab_tbl = bus.cmd_tbl;
    end
  end

  task automatic pulse_start(input bit expect_start);
    @(negedge clk);
    #2;
    start = 1'b1;
    while (!ce) begin
      @(negedge clk);
      #2;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_start) begin
      chk("start_busy", bus.busy, 1'b1);
      chk("start_cef", bus.cef, 1'b0);
      chk("start_bef", bus.bef, m_cef);
      chk("start_copr", bus.copr, 16'h0000);
    end else chk("restart_ignored_busy", bus.busy, 1'b1);
  endtask

  task automatic begin_walk();
    if (!model(1)) chk("model_terminates", 1'b0, 1'b1);
    pulse_start(1);
  endtask

  task automatic finish_walk(input string nm);
    int cyc = 0;
    while (bus.busy && cyc < 6000) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    chk({nm, "_done"}, bus.busy, 1'b0);
    chk({nm, "_cef"}, bus.cef, 1'b1);
    chk({nm, "_lopr"}, bus.lopr, m_lopr);
    chk({nm, "_copr"}, bus.copr, m_copr);
    chk({nm, "_reads_left"}, 32'(exp_addr.size()), 32'd0);
    chk({nm, "_cmds_left"}, 32'(exp_cmd.size()), 32'd0);
    exp_addr.delete();
    exp_cmd.delete();
    m_cef = 1;
  endtask

  task automatic run_walk(input string nm);
    begin_walk();
    finish_walk(nm);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_vram_rd", bus.vram_rd, 1'b0);
    chk("rst_vram_a", bus.vram_a, 18'h0);
    chk("rst_cmd_valid", bus.cmd_valid, 1'b0);
    chk("rst_cmd_tbl", bus.cmd_tbl, 256'h0);
    chk("rst_copr", bus.copr, 16'h0);
    chk("rst_lopr", bus.lopr, 16'h0);
    chk("rst_cef", bus.cef, 1'b0);
    chk("rst_bef", bus.bef, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;

    mem.delete();
    wr_tbl(16'h0000, 16'h8000, 16'h0000);
    run_walk("end_at_0");

    mem.delete();
    wr_tbl(16'h0000, 16'h0000, 16'h0000);
    wr_tbl(16'h0004, 16'h8000, 16'h0000);
    hold_low = 1;
    begin_walk();
    cyc = 0;
    while (!bus.cmd_valid && cyc < 2000) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    chk("nspr_valid_up", bus.cmd_valid, 1'b1);
    pulse_start(0);
    repeat (5) @(negedge clk);
    #2;
    chk("nspr_valid_held", bus.cmd_valid, 1'b1);
    chk("nspr_word1e", bus.cmd_tbl[255:240], 16'h0000);
    hold_low = 0;
    finish_walk("nspr");

    mem.delete();
    wr_tbl(16'h0000, 16'h1000, 16'h0103);
    wr_tbl(16'h0100, 16'h8000, 16'h0000);
    run_walk("assign");

    mem.delete();
    wr_tbl(16'h0000, 16'h2000, 16'h0040);
    wr_tbl(16'h0040, 16'h3000, 16'h0000);
    wr_tbl(16'h0004, 16'h8000, 16'h0000);
    run_walk("call_ret");

    mem.delete();
    wr_tbl(16'h0000, 16'h8000, 16'h0000);
    run_walk("end_keeps_lopr");

    mem.delete();
    wr_tbl(16'h0000, 16'h2000, 16'h0040);
    wr_tbl(16'h0040, 16'h2000, 16'h0080);
    wr_tbl(16'h0080, 16'h3000, 16'h0000);
    wr_tbl(16'h0004, 16'h8000, 16'h0000);
    run_walk("nested_call");

    mem.delete();
    wr_tbl(16'h0000, 16'h4000, 16'h0010);
    wr_tbl(16'h0004, 16'h8000, 16'h0000);
    run_walk("skip");
    ce_rand = 1;
    run_walk("skip_ce");
    ce_rand = 0;

    mem.delete();
    wr_tbl(16'h0000, 16'h5000, 16'h0022);
    wr_tbl(16'h0020, 16'h8000, 16'h0000);
    run_walk("skip_assign");

    mem.delete();
    wr_tbl(16'h0000, 16'h3000, 16'h0000);
    wr_tbl(16'h0004, 16'h2000, 16'hFFF8);
    wr_tbl(16'hFFF8, 16'h0000, 16'h0000);
    wr_tbl(16'hFFFC, 16'h0000, 16'h0000);
    wr_tbl(16'h0008, 16'h8000, 16'h0000);
    run_walk("wrap");

    for (int k = 0; k < 15; k++) begin
      do begin
        mem.delete();
        for (int t = 0; t < 64; t++) wr_rand(16'(t * 4));
      end while (!model(0));
      ce_rand = 1;
      run_walk("random");
      ce_rand = 0;
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
